// File: rtl/mulvec_sched.sv
// mulvec_sched: round-robin scheduler sharing one vectorial multiplier among NUM_REQ requesters
// with in-flight tracking, a credit-guarded response FIFO and in-order responses.
module mulvec_sched #(
    parameter int NUM_REQ    = 2,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4,
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*128-1:0] req_srca,
    input  logic [NUM_REQ*128-1:0] req_srcb,
    input  logic [NUM_REQ*3-1:0]   req_sel,
    input  logic [NUM_REQ-1:0]     req_is_mul,
    input  logic [NUM_REQ-1:0]     req_is_high,
    input  logic [NUM_REQ-1:0]     req_is_signed,
    output logic [127:0]           mul_srca,
    output logic [127:0]           mul_srcb,
    output logic [2:0]             mul_sel,
    output logic                   mul_is_mul,
    output logic                   mul_is_high,
    output logic                   mul_is_signed,
    input  logic [127:0]           mul_result,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IW-1:0]          rsp_id,
    output logic [127:0]           rsp_result
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + LATENCY + 1);

    logic [IW-1:0]  rr_ptr;
    logic [IW-1:0]  grant;
    logic           found;
    logic           issue_ok;
    logic           issue;
    logic           push;
    logic           pop;
    logic [CW-1:0]  fifo_count;
    logic [CW-1:0]  inflight_count;
    logic [LATENCY-1:0] pipe_v;
    logic [IW-1:0]  pipe_id [LATENCY];
    logic [127:0]   mem_res [FIFO_DEPTH];
    logic [IW-1:0]  mem_id [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    // Two passes give the wrap-around search: first from rr_ptr upward, then below it.
    always_comb begin
        found = 1'b0;
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i] && i >= int'(rr_ptr)) begin
                found = 1'b1;
                grant = IW'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i] && i < int'(rr_ptr)) begin
                found = 1'b1;
                grant = IW'(i);
            end
        end
    end

    // Credit counts only registered occupancy, so a same-cycle pop frees nothing yet.
    assign issue_ok  = (fifo_count + inflight_count) < CW'(FIFO_DEPTH);
    assign issue     = found & issue_ok & ~rst;
    assign req_ready = issue ? NUM_REQ'(1) << grant : '0;

    assign mul_srca      = issue ? req_srca[int'(grant)*128 +: 128] : '0;
    assign mul_srcb      = issue ? req_srcb[int'(grant)*128 +: 128] : '0;
    assign mul_sel       = issue ? req_sel[int'(grant)*3 +: 3] : '0;
    assign mul_is_mul    = issue & req_is_mul[grant];
    assign mul_is_high   = issue & req_is_high[grant];
    assign mul_is_signed = issue & req_is_signed[grant];

    assign push       = pipe_v[LATENCY-1];
    assign rsp_valid  = (fifo_count != '0) & ~rst;
    assign pop        = rsp_valid & rsp_ready;
    assign rsp_result = mem_res[rd_ptr];
    assign rsp_id     = mem_id[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr         <= '0;
            pipe_v         <= '0;
            inflight_count <= '0;
            fifo_count     <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
        end else begin
            if (issue)
                rr_ptr <= (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
            pipe_v[0] <= issue;
            for (int i = 1; i < LATENCY; i++)
                pipe_v[i] <= pipe_v[i-1];
            inflight_count <= inflight_count + CW'(issue) - CW'(push);
            fifo_count     <= fifo_count + CW'(push) - CW'(pop);
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Payload storage needs no reset; validity lives in pipe_v and fifo_count.
    always_ff @(posedge clk) begin
        pipe_id[0] <= grant;
        for (int i = 1; i < LATENCY; i++)
            pipe_id[i] <= pipe_id[i-1];
        if (push) begin
            mem_res[wr_ptr] <= mul_result;
            mem_id[wr_ptr]  <= pipe_id[LATENCY-1];
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(push && fifo_count == CW'(FIFO_DEPTH)));
endmodule

// File: tb/tb_mulvec_sched.sv
// tb_mulvec_sched: randomized bench with a queue-based scheduler model, a pipelined
// multiplier model, and directed literal checks.
module tb_mulvec_sched;
    localparam int N = 2;
    localparam int LAT = 2;
    localparam int D = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*128-1:0] req_srca;
    logic [N*128-1:0] req_srcb;
    logic [N*3-1:0] req_sel;
    logic [N-1:0]   req_is_mul;
    logic [N-1:0]   req_is_high;
    logic [N-1:0]   req_is_signed;
    logic [127:0]   mul_srca;
    logic [127:0]   mul_srcb;
    logic [2:0]     mul_sel;
    logic           mul_is_mul;
    logic           mul_is_high;
    logic           mul_is_signed;
    logic [127:0]   mul_result;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [0:0]     rsp_id;
    logic [127:0]   rsp_result;

    int ncmp = 0;
    int nerr = 0;

    mulvec_sched #(.NUM_REQ(N), .LATENCY(LAT), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_srca(req_srca), .req_srcb(req_srcb), .req_sel(req_sel),
        .req_is_mul(req_is_mul), .req_is_high(req_is_high), .req_is_signed(req_is_signed),
        .mul_srca(mul_srca), .mul_srcb(mul_srcb), .mul_sel(mul_sel),
        .mul_is_mul(mul_is_mul), .mul_is_high(mul_is_high), .mul_is_signed(mul_is_signed),
        .mul_result(mul_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result)
    );

    always #5 clk = ~clk;

    // Lane-wise reference product: low or high half of each 2w-bit lane product.
    function automatic logic [127:0] vmul(input logic [127:0] a, input logic [127:0] b,
                                          input logic [2:0] sel, input logic m, input logic h,
                                          input logic s);
        logic [255:0] x;
        logic [255:0] y;
        logic [255:0] p;
        logic [127:0] r;
        int w;
        r = '0;
        if (sel > 3'd4) return '0;
        if (!m) return a;
        w = 8 << sel;
        for (int l = 0; l < 128 / w; l++) begin
            x = '0;
            y = '0;
            for (int k = 0; k < w; k++) begin
                x[k] = a[l*w+k];
                y[k] = b[l*w+k];
            end
            if (s) begin
                for (int k = w; k < 256; k++) begin
                    x[k] = x[w-1];
                    y[k] = y[w-1];
                end
            end
            p = x * y;
            for (int k = 0; k < w; k++) r[l*w+k] = h ? p[w+k] : p[k];
        end
        return r;
    endfunction

    logic [127:0] mp [LAT];
    always @(posedge clk) begin
        for (int k = LAT - 1; k > 0; k--) mp[k] <= mp[k-1];
        mp[0] <= vmul(mul_srca, mul_srcb, mul_sel, mul_is_mul, mul_is_high, mul_is_signed);
    end
    assign mul_result = mp[LAT-1];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Behavioural model: occupancy = queue sizes, results ready LAT cycles after issue.
    typedef struct { int id; logic [127:0] r; int due; } ent_t;
    ent_t pend[$];
    ent_t fifo[$];
    int rr = 0;
    int cyc = 0;

    always @(negedge clk) begin
        int g;
        bit iss;
        bit ev;
        ent_t e;
        logic [127:0] ea;
        logic [127:0] eb;
        logic [5:0] ef;
        g = -1;
        for (int k = 0; k < N; k++)
            if (g < 0 && req_valid[(rr + k) % N]) g = (rr + k) % N;
        iss = !rst && g >= 0 && (fifo.size() + pend.size() < D);
        ea = '0;
        eb = '0;
        ef = '0;
        if (iss) begin
            ea = req_srca[g*128 +: 128];
            eb = req_srcb[g*128 +: 128];
            ef = {req_sel[g*3 +: 3], req_is_mul[g], req_is_high[g], req_is_signed[g]};
        end
        chk("m_req_ready", req_ready, iss ? (2'b01 << g) : 2'b00);
        chk("m_mul_srca", mul_srca, ea);
        chk("m_mul_srcb", mul_srcb, eb);
        chk("m_mul_ctl", {mul_sel, mul_is_mul, mul_is_high, mul_is_signed}, ef);
        ev = !rst && fifo.size() > 0;
        chk("m_rsp_valid", rsp_valid, ev);
        if (ev) begin
            chk("m_rsp_id", rsp_id, fifo[0].id);
            chk("m_rsp_result", rsp_result, fifo[0].r);
        end
        if (rst) begin
            pend.delete();
            fifo.delete();
            rr = 0;
        end else begin
            if (ev && rsp_ready) void'(fifo.pop_front());
            if (pend.size() > 0 && pend[0].due == cyc) fifo.push_back(pend.pop_front());
            if (iss) begin
                e.id = g;
                e.r = vmul(ea, eb, ef[5:3], ef[2], ef[1], ef[0]);
                e.due = cyc + LAT;
                pend.push_back(e);
                rr = (g + 1) % N;
            end
        end
        cyc++;
    end

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        req_valid = '0;
    endtask

    task automatic drive(input int i, input logic [127:0] a, input logic [127:0] b,
                         input logic [2:0] s, input logic m, input logic h, input logic sg);
        req_valid[i] = 1'b1;
        req_srca[i*128 +: 128] = a;
        req_srcb[i*128 +: 128] = b;
        req_sel[i*3 +: 3] = s;
        req_is_mul[i] = m;
        req_is_high[i] = h;
        req_is_signed[i] = sg;
    endtask

    task automatic drive_rand(input int i);
        drive(i, rand128(), rand128(), 3'($urandom_range(0, 7)), 1'($urandom),
              1'($urandom), 1'($urandom));
    endtask

    task automatic one_op(input int i, input logic [127:0] a, input logic [127:0] b,
                          input logic [2:0] s, input logic m, input logic h, input logic sg,
                          output logic [127:0] res, output int id, output int lat);
        step();
        clear_req();
        drive(i, a, b, s, m, h, sg);
        @(negedge clk);
        chk("op_grant", req_ready, 2'b01 << i);
        res = '0;
        id = -1;
        lat = 0;
        for (int n = 0; n < 10; n++) begin
            step();
            clear_req();
            @(negedge clk);
            lat++;
            if (rsp_valid) begin
                res = rsp_result;
                id = int'(rsp_id);
                break;
            end
        end
    endtask

    initial begin
        logic [127:0] res;
        int id;
        int lat;
        int hs;
        int rs;
        rst = 1'b1;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_srca = '0;
        req_srcb = '0;
        req_sel = '0;
        req_is_mul = '0;
        req_is_high = '0;
        req_is_signed = '0;
        step();
        drive_rand(0);
        @(negedge clk);
        chk("reset_ready", req_ready, 0);
        chk("reset_valid", rsp_valid, 0);
        step();
        rst = 1'b0;
        clear_req();
        step();
        drive(0, {16{8'h03}}, {16{8'h05}}, 3'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("single_grant", req_ready, 2'b01);
        for (int k = 1; k <= 3; k++) begin
            step();
            clear_req();
            @(negedge clk);
            chk("single_latency", rsp_valid, k == 3);
        end
        chk("single_id", rsp_id, 0);
        chk("single_result", rsp_result, {16{8'h0F}});
        for (int i = 0; i < 11; i++) begin
            step();
            if (i < 8) begin
                drive_rand(0);
                drive_rand(1);
            end else clear_req();
            @(negedge clk);
            if (i < 8) chk("fair_grant", req_ready, (i % 2 == 0) ? 2'b10 : 2'b01);
            if (i >= 3) begin
                chk("fair_rsp_valid", rsp_valid, 1);
                chk("fair_rsp_id", rsp_id, ((i - 3) % 2 == 0) ? 1 : 0);
            end
        end
        repeat (5) begin
            step();
            clear_req();
        end
        rsp_ready = 1'b0;
        hs = 0;
        rs = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            drive_rand(0);
            @(negedge clk);
            if (req_valid[0] && req_ready[0]) hs++;
        end
        chk("bp_accepted", hs, 4);
        chk("bp_blocked", req_ready, 0);
        for (int n = 0; n < 200 && rs < 20; n++) begin
            step();
            rsp_ready = 1'b1;
            clear_req();
            if (hs < 20) drive_rand(0);
            @(negedge clk);
            if (req_valid[0] && req_ready[0]) hs++;
            if (rsp_valid && rsp_ready) rs++;
        end
        chk("bp_issued", hs, 20);
        chk("bp_responses", rs, 20);
        step();
        clear_req();
        @(negedge clk);
        chk("bp_no_dup", rsp_valid, 0);
        one_op(0, {16{8'hFF}}, {16{8'h02}}, 3'd0, 1'b1, 1'b1, 1'b1, res, id, lat);
        chk("sh_result", res, {16{8'hFF}});
        chk("sh_id", id, 0);
        chk("sh_latency", lat, 3);
        one_op(1, {16{8'hFF}}, {16{8'h02}}, 3'd4, 1'b1, 1'b1, 1'b0, res, id, lat);
        chk("u128_high", res, {{15{8'h02}}, 8'h01});
        chk("u128_id", id, 1);
        one_op(1, rand128(), rand128(), 3'd6, 1'b1, 1'b0, 1'b0, res, id, lat);
        chk("sel6_result", res, 0);
        chk("sel6_id", id, 1);
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            clear_req();
            drive_rand(0);
        end
        step();
        rst = 1'b1;
        drive_rand(0);
        drive_rand(1);
        @(negedge clk);
        chk("midrst_valid", rsp_valid, 0);
        chk("midrst_ready", req_ready, 0);
        step();
        rst = 1'b0;
        clear_req();
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("midrst_stale", rsp_valid, 0);
            step();
        end
        drive_rand(0);
        drive_rand(1);
        @(negedge clk);
        chk("midrst_rr", req_ready, 2'b01);
        step();
        clear_req();
        drive_rand(1);
        @(negedge clk);
        chk("midrst_req1", req_ready, 2'b10);
        for (int n = 0; n < 3000; n++) begin
            step();
            rst = ($urandom_range(0, 299) == 0);
            clear_req();
            for (int i = 0; i < N; i++) if ($urandom_range(0, 3) != 0) drive_rand(i);
            rsp_ready = (n / 200) % 3 == 1 ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 3) != 0);
        end
        step();
        rst = 1'b0;
        clear_req();
        rsp_ready = 1'b1;
        repeat (12) step();
        @(negedge clk);
        chk("final_drained", rsp_valid, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
